// File: rtl/rle_dec_if.sv
// Run-length decoder FIFO-side bundle: input FIFO pop port, output FIFO
// push port, end-of-stream flag and completion flag.
interface rle_dec_if #(
    parameter int CNT_W = 23
);
    logic             recv_ready;
    logic             rd_req;
    logic [CNT_W:0]   in_data;
    logic             send_ready;
    logic             wr_req;
    logic [7:0]       out_data;
    logic             end_of_stream;
    logic             done;

    // Decoder side: pops run words, pushes bytes.
    modport master (
        input  recv_ready,
        input  in_data,
        input  send_ready,
        input  end_of_stream,
        output rd_req,
        output wr_req,
        output out_data,
        output done
    );

    // FIFO / environment side.
    modport slave (
        output recv_ready,
        output in_data,
        output send_ready,
        output end_of_stream,
        input  rd_req,
        input  wr_req,
        input  out_data,
        input  done
    );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: pops {bit, length} run words from an input FIFO,
// expands each run one bit per cycle into a byte buffer (LSB first) and
// pushes completed bytes to an output FIFO. On end-of-stream any partial
// byte is flushed zero-padded, after which done is raised and held.
module rle_dec #(
    parameter int CNT_W = 23
) (
    input  logic     clk,
    input  logic     rst,
    rle_dec_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_EMIT  = 3'd5,
        ST_WOUT  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nx_s;

    logic [CNT_W-1:0] count_r;
    logic             value_r;
    logic [3:0]       bit_ptr_r;
    logic [7:0]       byte_buf_r;
    logic             flush_r;

    logic             rd_req_r;
    logic             wr_req_r;
    logic [7:0]       out_data_r;
    logic             done_r;

    logic [CNT_W-1:0] ld_cnt_s;
    logic [CNT_W-1:0] count_dec_s;
    logic [3:0]       bit_ptr_inc_s;
    logic             flush_set_s;

    // Run length field of the word presented by the input FIFO.
    assign ld_cnt_s = bus.in_data[CNT_W-1:0];

    // Saturating decrement and bit-pointer increment used by SHIFT.
    always_comb begin
        bit_ptr_inc_s = bit_ptr_r + 4'd1;
        if (count_r != CNT_ZERO) begin
            count_dec_s = count_r - CNT_ONE;
        end else begin
            count_dec_s = count_r;
        end
    end

    // Next-state logic of the decode FSM.
    always_comb begin
        state_nx_s  = state_r;
        flush_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_REQ;
            end
            ST_REQ: begin
                // A pending word always takes priority over end of stream.
                if (bus.recv_ready) begin
                    state_nx_s = ST_WAIT;
                end else if (bus.end_of_stream) begin
                    if (bit_ptr_r != 4'd0) begin
                        state_nx_s  = ST_EMIT;
                        flush_set_s = 1'b1;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                state_nx_s = ST_LOAD;
            end
            ST_LOAD: begin
                // Zero-length runs carry no bits and are dropped.
                if (ld_cnt_s == CNT_ZERO) begin
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A full byte wins; the remaining count resumes after the emit.
                if (bit_ptr_inc_s == 4'd8) begin
                    state_nx_s = ST_EMIT;
                end else if (count_dec_s == CNT_ZERO) begin
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_EMIT: begin
                if (bus.send_ready) begin
                    state_nx_s = ST_WOUT;
                end else begin
                    state_nx_s = ST_EMIT;
                end
            end
            ST_WOUT: begin
                if (flush_r) begin
                    state_nx_s = ST_DONE;
                end else if (count_r != CNT_ZERO) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_DONE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Run latch, bit expansion into the byte buffer, and buffer clear on emit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_r    <= 1'b0;
            count_r    <= CNT_ZERO;
            bit_ptr_r  <= 4'd0;
            byte_buf_r <= 8'h00;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    value_r <= bus.in_data[CNT_W];
                    count_r <= ld_cnt_s;
                end
                ST_SHIFT: begin
                    byte_buf_r[bit_ptr_r[2:0]] <= value_r;
                    bit_ptr_r                  <= bit_ptr_inc_s;
                    count_r                    <= count_dec_s;
                end
                ST_WOUT: begin
                    byte_buf_r <= 8'h00;
                    bit_ptr_r  <= 4'd0;
                end
                default: begin
                    byte_buf_r <= byte_buf_r;
                end
            endcase
        end
    end

    // Remember that the current emit is the final end-of-stream flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_r <= 1'b0;
        end else if (flush_set_s) begin
            flush_r <= 1'b1;
        end
    end

    // Registered handshake outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_req_r   <= 1'b0;
            wr_req_r   <= 1'b0;
            done_r     <= 1'b0;
            out_data_r <= 8'h00;
        end else begin
            rd_req_r <= (state_nx_s == ST_WAIT);
            wr_req_r <= (state_nx_s == ST_WOUT);
            done_r   <= (state_nx_s == ST_DONE);
            if ((state_nx_s == ST_WOUT) && (state_r != ST_WOUT)) begin
                out_data_r <= byte_buf_r;
            end
        end
    end

    assign bus.rd_req   = rd_req_r;
    assign bus.wr_req   = wr_req_r;
    assign bus.out_data = out_data_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_rle_dec.sv
// Self-checking bench for rle_dec: an input FIFO model feeds run words,
// expected bytes go to a scoreboard queue and are compared on each wr_req.
module tb_rle_dec;

    localparam int CNT_W = 23;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rle_dec_if #(.CNT_W(CNT_W)) bus ();

    rle_dec #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           n_w;
        logic [23:0]  w [4];
        logic         eos;
        int           n_b;
        logic [7:0]   b [4];
    } vec_t;

    vec_t        tbl [8];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rr_rise_cyc = 0;
    int          wr_first_cyc = 0;
    int          rd_first_cyc = 0;
    logic [23:0] wq [$];
    logic [7:0]  sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mkw(logic v, int n);
        logic [22:0] c;
        c = 23'(n);
        return {v, c};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Input FIFO model and output monitor, both evaluated on the falling edge.
    initial begin
        logic        rr_new;
        logic [7:0]  exp_b;
        bus.recv_ready = 1'b0;
        bus.in_data    = 24'd0;
        forever begin
            @(negedge clk);
            if (bus.rd_req === 1'b1) begin
                rd_cnt++;
                if (rd_cnt == 1) rd_first_cyc = cyc;
                checks++;
                if (bus.recv_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_req_when_empty: recv_ready=%0b expected 1", bus.recv_ready);
                end
                if (wq.size() != 0) bus.in_data = wq.pop_front();
            end
            if (bus.wr_req === 1'b1) begin
                wr_cnt++;
                if (wr_cnt == 1) wr_first_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got byte 0x%02h expected no write", bus.out_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (bus.out_data !== exp_b) begin
                        errors++;
                        $display("FAIL out_data: got 0x%02h expected 0x%02h", bus.out_data, exp_b);
                    end
                end
            end
            rr_new = (wq.size() != 0);
            if (rr_new && !bus.recv_ready) rr_rise_cyc = cyc;
            bus.recv_ready = rr_new;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.send_ready    = 1'b1;
        bus.end_of_stream = 1'b0;
        wq.delete();
        sb.delete();
        repeat (3) @(negedge clk);
        wr_cnt = 0;
        rd_cnt = 0;
        rst = 1'b1;
    endtask

    task automatic wait_wr(int n, int budget);
        int k;
        k = 0;
        while (wr_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(int idx, vec_t v);
        int k;
        do_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < v.n_w; i++) wq.push_back(v.w[i]);
        for (int i = 0; i < v.n_b; i++) sb.push_back(v.b[i]);
        repeat (2) @(negedge clk);
        bus.end_of_stream = v.eos;
        k = 0;
        while (k < 400 && ((v.eos && bus.done !== 1'b1) || (!v.eos && wr_cnt < v.n_b))) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        check($sformatf("vec%0d_wr_count", idx), wr_cnt, v.n_b);
        check($sformatf("vec%0d_rd_count", idx), rd_cnt, v.n_w);
        check($sformatf("vec%0d_done", idx), int'(bus.done === 1'b1), int'(v.eos));
        check($sformatf("vec%0d_sb_left", idx), sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stimulus table: run words and the bytes they must decode to.
        tbl[0].n_w = 2; tbl[0].w[0] = mkw(1'b1, 5);  tbl[0].w[1] = mkw(1'b0, 3);
        tbl[0].eos = 1'b0; tbl[0].n_b = 1; tbl[0].b[0] = 8'h1F;
        tbl[1].n_w = 2; tbl[1].w[0] = mkw(1'b1, 16); tbl[1].w[1] = mkw(1'b0, 8);
        tbl[1].eos = 1'b0; tbl[1].n_b = 3;
        tbl[1].b[0] = 8'hFF; tbl[1].b[1] = 8'hFF; tbl[1].b[2] = 8'h00;
        tbl[2].n_w = 1; tbl[2].w[0] = mkw(1'b1, 3);
        tbl[2].eos = 1'b1; tbl[2].n_b = 1; tbl[2].b[0] = 8'h07;
        tbl[3].n_w = 2; tbl[3].w[0] = mkw(1'b0, 0);  tbl[3].w[1] = mkw(1'b1, 8);
        tbl[3].eos = 1'b0; tbl[3].n_b = 1; tbl[3].b[0] = 8'hFF;
        tbl[4].n_w = 2; tbl[4].w[0] = mkw(1'b0, 4);  tbl[4].w[1] = mkw(1'b1, 4);
        tbl[4].eos = 1'b0; tbl[4].n_b = 1; tbl[4].b[0] = 8'hF0;
        tbl[5].n_w = 3; tbl[5].w[0] = mkw(1'b1, 3);  tbl[5].w[1] = mkw(1'b0, 2);
        tbl[5].w[2] = mkw(1'b1, 7);
        tbl[5].eos = 1'b1; tbl[5].n_b = 2; tbl[5].b[0] = 8'hE7; tbl[5].b[1] = 8'h0F;
        tbl[6].n_w = 1; tbl[6].w[0] = mkw(1'b0, 12);
        tbl[6].eos = 1'b1; tbl[6].n_b = 2; tbl[6].b[0] = 8'h00; tbl[6].b[1] = 8'h00;
        tbl[7].n_w = 0;
        tbl[7].eos = 1'b1; tbl[7].n_b = 0;

        // Reset values, taken while reset is asserted.
        rst = 1'b1;
        bus.send_ready    = 1'b1;
        bus.end_of_stream = 1'b0;
        #2 rst = 1'b0;
        #2;
        check("reset_rd_req", int'(bus.rd_req), 0);
        check("reset_wr_req", int'(bus.wr_req), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_done", int'(bus.done), 0);

        // First-byte latency of {1,8} and rd_req position.
        do_reset();
        repeat (3) @(negedge clk);
        wq.push_back(mkw(1'b1, 8));
        sb.push_back(8'hFF);
        wait_wr(1, 100);
        repeat (4) @(negedge clk);
        check("latency_wr", wr_first_cyc - rr_rise_cyc, 12);
        check("latency_rd", rd_first_cyc - rr_rise_cyc, 1);
        check("latency_sb_left", sb.size(), 0);

        // Output stall: byte ready while send_ready is low.
        do_reset();
        bus.send_ready = 1'b0;
        repeat (3) @(negedge clk);
        wq.push_back(mkw(1'b1, 8));
        wq.push_back(mkw(1'b1, 8));
        sb.push_back(8'hFF);
        sb.push_back(8'hFF);
        repeat (25) @(negedge clk);
        check("stall_wr_count", wr_cnt, 0);
        check("stall_rd_count", rd_cnt, 1);
        bus.send_ready = 1'b1;
        wait_wr(1, 20);
        check("stall_release_wr", wr_cnt, 1);
        wait_wr(2, 100);
        repeat (5) @(negedge clk);
        check("stall_total_wr", wr_cnt, 2);
        check("stall_total_rd", rd_cnt, 2);
        check("stall_sb_left", sb.size(), 0);

        // Asynchronous reset in the middle of {1,20}.
        do_reset();
        repeat (3) @(negedge clk);
        wq.push_back(mkw(1'b1, 20));
        sb.push_back(8'hFF);
        repeat (17) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_rd_req", int'(bus.rd_req), 0);
        check("midrst_wr_req", int'(bus.wr_req), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_wr_count", wr_cnt, 1);
        check("midrst_sb_left", sb.size(), 0);
        repeat (4) @(negedge clk);
        check("midrst_no_wr", wr_cnt, 1);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            run_vec(i, tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_dec.md
# rle_dec

Run-length decoder: the stage directly downstream of the run-length encoder's output FIFO. It pops 24-bit run words ({bit ID, 23-bit run length}), expands each run back into a bit stream, and repacks the bits into 8-bit bytes. Bytes go to an output FIFO. It uses the same single-cycle rd_req/wr_req FIFO handshake as the encoder, so encoder → FIFO → decoder round-trips the original byte stream.

## Interface
- CNT_W, 23, run-length field width; in_data is CNT_W+1 bits wide.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- recv_ready  in  1  input FIFO not empty.
- rd_req  out  1  input FIFO read request, one-cycle pulse.
- in_data  in  CNT_W+1  run word: [CNT_W] = bit value, [CNT_W-1:0] = run length.
- send_ready  in  1  output FIFO not full.
- wr_req  out  1  output FIFO write request, one-cycle pulse.
- out_data  out  8  decoded byte; bit 0 is the earliest bit in the stream.
- end_of_stream  in  1  no further run words will arrive; flush any partial byte.
- done  out  1  high after the final byte is written; held until reset.

## Operation
- States and transitions:
  - IDLE → REQ.
  - REQ:
    - if recv_ready → WAIT;
    - else if end_of_stream and bit_ptr≠0 → EMIT (flush);
    - else if end_of_stream and bit_ptr=0 → DONE;
    - else stay in REQ.
  - WAIT → LOAD.
  - LOAD: latch value ← in_data[CNT_W] and count ← in_data[CNT_W-1:0].
    - if count = 0 → REQ (word discarded);
    - else → SHIFT.
  - SHIFT (1 bit per cycle): byte_buf[bit_ptr] ← value; bit_ptr += 1; count -= 1. Then:
    - if bit_ptr reaches 8 → EMIT;
    - else if count reaches 0 → REQ;
    - else stay in SHIFT.
  - EMIT: stay until send_ready, then → WOUT.
  - WOUT (wr_req high this cycle). Then clear byte_buf and bit_ptr, and:
    - if flushing → DONE;
    - else if count≠0 → SHIFT;
    - else → REQ.
  - DONE: terminal; done=1.
- bit_ptr is 4 bits (0..8) and resets to 0 after each emit.
- count is CNT_W bits and never wraps; a count of 0 is never decremented.
- Flushed partial byte: positions ≥ bit_ptr are 0.
- end_of_stream is sampled only in REQ. A word already accepted is fully expanded before the flush.
- Runs that span byte boundaries continue seamlessly after the emit; no bits are lost or duplicated.

## Timing
- Reset values: rd_req=0, wr_req=0, out_data=0x00, done=0, state=IDLE, count=0, bit_ptr=0, byte_buf=0.
- Reset asserted mid-run aborts immediately. Partial byte and count are discarded, and no wr_req is issued.
- rd_req:
  - high for exactly the cycle spent in WAIT, i.e. the cycle after REQ saw recv_ready;
  - in_data is sampled at the end of LOAD, one cycle after rd_req;
  - never asserted while recv_ready=0.
- wr_req:
  - high for exactly one cycle (WOUT);
  - asserted only if send_ready was high in the preceding EMIT cycle;
  - out_data is updated on entry to WOUT and held stable until the next WOUT.
- Latency:
  - a run of N bits costs 3 cycles (REQ/WAIT/LOAD) plus N SHIFT cycles, plus 2 cycles per emitted byte when unstalled;
  - first byte of {1,8}: wr_req 12 cycles after REQ entry with recv_ready high.
- Simultaneous recv_ready and end_of_stream in REQ: recv_ready wins; the word is consumed first.
- send_ready low: EMIT stalls indefinitely with wr_req=0. No input read occurs while stalled.

## Test plan
- Words {1,5} then {0,3}: exactly one wr_req, out_data=0x1F; decoder returns to REQ.
- Word {1,16}: two wr_req pulses, both 0xFF. Then {0,8}: one wr_req with 0x00.
- Word {1,3}, then recv_ready=0 with end_of_stream=1: one wr_req with 0x07, then done=1 held; no further rd_req.
- Word {0,0} followed by {1,8}: the first word produces no output bits; a single 0xFF is written.
- Byte ready with send_ready=0 for 10 cycles: wr_req stays 0 and no rd_req occurs. On release, exactly one wr_req with the correct byte.
- rst pulled low mid-run during {1,20}: all outputs return to reset values asynchronously. After release, words {0,4},{1,4} yield 0xF0.
